// File: rtl/residue_check_seq.sv
// residue_check_seq: sequential mod-(2^K-1) residue checker for ALU add/mul results.
// Optional saturating error counter enabled by defining RES_ERR_COUNT_EN.
module residue_check_seq #(
    parameter int DATA_W   = 32,
    parameter int MOD_BITS = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                op,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    input  logic [DATA_W-1:0]   res_hi,
    input  logic [DATA_W-1:0]   res_lo,
    output logic                out_valid,
    output logic                out_error,
    output logic [MOD_BITS-1:0] res_pred,
    output logic [MOD_BITS-1:0] res_actual,
    output logic [CNT_W-1:0]    err_count
);
    localparam int K  = MOD_BITS;
    localparam int NF = (2*DATA_W + K - 1) / K;
    localparam int CW = $clog2(NF + 1);
    typedef enum logic [1:0] {IDLE, FOLD, CHECK, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0]       cnt;
    logic                op_q;
    logic [DATA_W-1:0]   sa, sb;
    logic [2*DATA_W-1:0] sr;
    logic [K-1:0]        acc_a, acc_b, acc_r, pred_q, act_q, ra, rb, pred_c;
    logic [2*K-1:0]      ra_w, rb_w, raw;
    // Add with end-around carry; the result never overflows a second time.
    function automatic logic [K-1:0] eac(input logic [K-1:0] x, input logic [K-1:0] y);
        logic [K:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[K-1:0] + {{(K-1){1'b0}}, s[K]};
    endfunction
    function automatic logic [K-1:0] canon(input logic [K-1:0] x);
        return (x == {K{1'b1}}) ? '0 : x;
    endfunction
    assign in_ready = (state == IDLE);
    assign ra       = canon(acc_a);
    assign rb       = canon(acc_b);
    assign ra_w     = {{K{1'b0}}, ra};
    assign rb_w     = {{K{1'b0}}, rb};
    assign raw      = op_q ? ra_w * rb_w : ra_w + rb_w;
    assign pred_c   = canon(eac(raw[2*K-1:K], raw[K-1:0]));
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? FOLD : IDLE;
            FOLD:    state_nx = (cnt == CW'(NF - 1)) ? CHECK : FOLD;
            CHECK:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            op_q       <= 1'b0;
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            acc_a      <= '0;
            acc_b      <= '0;
            acc_r      <= '0;
            pred_q     <= '0;
            act_q      <= '0;
            out_valid  <= 1'b0;
            out_error  <= 1'b0;
            res_pred   <= '0;
            res_actual <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    op_q  <= op;
                    sa    <= op_a;
                    sb    <= op_b;
                    sr    <= {res_hi, res_lo};
                    acc_a <= '0;
                    acc_b <= '0;
                    acc_r <= '0;
                    cnt   <= '0;
                end
                // Every K-bit chunk has weight 1 mod 2^K-1, so plain summation suffices.
                FOLD: begin
                    sa    <= sa >> K;
                    sb    <= sb >> K;
                    sr    <= sr >> K;
                    acc_a <= eac(acc_a, sa[K-1:0]);
                    acc_b <= eac(acc_b, sb[K-1:0]);
                    acc_r <= eac(acc_r, sr[K-1:0]);
                    cnt   <= cnt + CW'(1);
                end
                CHECK: begin
                    pred_q <= pred_c;
                    act_q  <= canon(acc_r);
                end
                default: begin
                    out_valid  <= 1'b1;
                    out_error  <= (pred_q != act_q);
                    res_pred   <= pred_q;
                    res_actual <= act_q;
                end
            endcase
        end
    end
`ifdef RES_ERR_COUNT_EN
    logic [CNT_W-1:0] err_cnt;
    always_ff @(posedge clock) begin
        if (reset)
            err_cnt <= '0;
        else if (state == DONE && pred_q != act_q && err_cnt != {CNT_W{1'b1}})
            err_cnt <= err_cnt + CNT_W'(1);
    end
    assign err_count = err_cnt;
`else
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_residue_check_seq.sv
// tb_residue_check_seq: directed self-checking bench for residue_check_seq (CNT_W=2).
module tb_residue_check_seq;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        op = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, res_hi = '0, res_lo = '0;
    logic        in_ready, out_valid, out_error;
    logic [4:0]  res_pred, res_actual;
    logic [1:0]  err_count;
    int          checks = 0;
    int          errors = 0;
`ifdef RES_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 clock = ~clock;

    residue_check_seq #(.DATA_W(32), .MOD_BITS(5), .CNT_W(2)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_a(op_a), .op_b(op_b), .res_hi(res_hi), .res_lo(res_lo),
        .out_valid(out_valid), .out_error(out_error), .res_pred(res_pred),
        .res_actual(res_actual), .err_count(err_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request from an idle cycle and wait for its result pulse.
    task automatic run(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo,
                       input int ep, input int ea, input int ee, input string tag);
        int lat;
        lat = 99;
        chk({tag, "_ready"}, in_ready, 1);
        op = o; op_a = a; op_b = b; res_hi = hi; res_lo = lo; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        op_a = '1; op_b = '1; res_hi = '1; res_lo = '1; op = ~o;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, lat, 15);
        chk({tag, "_pred"}, res_pred, ep);
        chk({tag, "_actual"}, res_actual, ea);
        chk({tag, "_error"}, out_error, ee);
        @(posedge clock); #1;
        chk({tag, "_pulse"}, out_valid, 0);
        chk({tag, "_hold"}, res_pred, ep);
    endtask

    initial begin
        int acc_t, lat;
        logic seen;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_error", out_error, 0);
        chk("rst_pred", res_pred, 0);
        chk("rst_actual", res_actual, 0);
        chk("rst_cnt", err_count, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        run(1'b0, 32'd10, 32'd21, 32'd0, 32'd31, 0, 0, 0, "add_basic");
        run(1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 4, 4, 0, "add_ovf");
        run(1'b1, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 6, 6, 0, "mul_big");
        run(1'b1, 32'd100, 32'd200, 32'd0, 32'd20000, 5, 5, 0, "mul_small");
        run(1'b0, 32'd5, 32'd7, 32'd0, 32'd13, 12, 13, 1, "fault");
        chk("cnt_fault", err_count, CNT_EN ? 1 : 0);
        run(1'b0, 32'd5, 32'd7, 32'd0, 32'd43, 12, 12, 0, "alias");
        chk("cnt_alias", err_count, CNT_EN ? 1 : 0);
        // Back-to-back requests with in_valid held high.
        op = 1'b0; op_a = 32'd10; op_b = 32'd21; res_hi = '0; res_lo = 32'd31;
        in_valid = 1'b1;
        acc_t = -1;
        @(posedge clock); #1;
        chk("hs_busy", in_ready, 0);
        for (int t = 1; t <= 40; t++) begin
            logic rdy;
            rdy = in_ready;
            @(posedge clock);
            if (rdy) begin
                acc_t = t;
                break;
            end
            #1;
        end
        #1;
        in_valid = 1'b0;
        chk("hs_gap", acc_t, 16);
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk("hs_lat2", lat, 15);
        chk("hs_err2", out_error, 0);
        @(posedge clock); #1;
        // Reset during the sixth fold cycle discards the transaction.
        op = 1'b0; op_a = 32'd5; op_b = 32'd7; res_hi = '0; res_lo = 32'd13;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cnt", err_count, 0);
        seen = 1'b0;
        repeat (25) begin
            @(posedge clock); #1;
            seen = seen | out_valid;
        end
        chk("mid_rst_noval", seen, 0);
        for (int k = 0; k < 5; k++) begin
            run(1'b0, 32'd5, 32'd7, 32'd0, 32'd13, 12, 13, 1, "sat");
            chk($sformatf("cnt_sat%0d", k), err_count, CNT_EN ? ((k < 3) ? k + 1 : 3) : 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
